// File: rtl/riscv_div_arbiter.sv
// Purpose: divide/remainder unit shared by two cores. A round-robin arbiter grants one
//          requester at a time, and a 32-step restoring divider computes the result.
// Latency: accept at T, valid_o pulse at T+33. With the fast path enabled, divide-by-zero,
//          signed overflow and b=1 produce valid_o at T+1.
// Backpressure: req_i is held until accept_o is seen. The losing core stays pending until
//          the FSM returns to IDLE. There is no queueing beyond the held request.
//
// Ports (cN = core 0 / core 1):
//   clk_i, rst_ni         clock; asynchronous active-low reset
//   cN_req_i / cN_op_i    request, op (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   cN_a_i / cN_b_i       dividend / divisor
//   cN_flush_i            abort this core's pending or in-flight request
//   cN_accept_o           combinational grant
//   cN_valid_o            registered one-cycle completion pulse
//   cN_result_o           registered result, held until the next completion for that core
// Optional feature macro: RISCV_DIV_FASTPATH_EN (single-cycle special cases).
module riscv_div_arbiter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        c0_req_i,
    input  logic [1:0]  c0_op_i,
    input  logic [31:0] c0_a_i,
    input  logic [31:0] c0_b_i,
    input  logic        c0_flush_i,
    output logic        c0_accept_o,
    output logic        c0_valid_o,
    output logic [31:0] c0_result_o,
    input  logic        c1_req_i,
    input  logic [1:0]  c1_op_i,
    input  logic [31:0] c1_a_i,
    input  logic [31:0] c1_b_i,
    input  logic        c1_flush_i,
    output logic        c1_accept_o,
    output logic        c1_valid_o,
    output logic [31:0] c1_result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        owner_q;      // core that owns the running operation
    logic        last_q;       // core served last; the other core wins a tie
    logic        op_rem_q;     // 1: return remainder, 0: return quotient
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [4:0]  cnt_q;

    // ---------------- arbitration ----------------
    logic elig0, elig1, grant_vld, grant_core;

    assign elig0      = c0_req_i & ~c0_flush_i;
    assign elig1      = c1_req_i & ~c1_flush_i;
    // Gated by rst_ni so that every output is low while reset is asserted.
    assign grant_vld  = rst_ni & (state_q == IDLE) & (elig0 | elig1);
    assign grant_core = (elig0 & elig1) ? ~last_q : elig1;

    assign c0_accept_o = grant_vld & ~grant_core;
    assign c1_accept_o = grant_vld &  grant_core;

    // ---------------- operand capture ----------------
    logic [1:0]  s_op;
    logic [31:0] s_a, s_b, a_mag, b_mag;
    logic        s_signed, a_neg, b_neg, b_zero;

    assign s_op     = grant_core ? c1_op_i : c0_op_i;
    assign s_a      = grant_core ? c1_a_i  : c0_a_i;
    assign s_b      = grant_core ? c1_b_i  : c0_b_i;
    assign s_signed = ~s_op[0];
    assign a_neg    = s_signed & s_a[31];
    assign b_neg    = s_signed & s_b[31];
    assign a_mag    = a_neg ? (32'd0 - s_a) : s_a;
    assign b_mag    = b_neg ? (32'd0 - s_b) : s_b;
    assign b_zero   = (s_b == 32'd0);

    // ---------------- fast path ----------------
    logic        fast_hit;
    logic [31:0] fast_res;

`ifdef RISCV_DIV_FASTPATH_EN
    // Overflow and b=1 share one result: the quotient is a and the remainder is 0.
    // Divide by zero returns an all-ones quotient and a as the remainder.
    assign fast_hit = b_zero | (s_b == 32'd1) |
                      (s_signed & (s_a == 32'h8000_0000) & (s_b == 32'hFFFF_FFFF));
    assign fast_res = s_op[1] ? (b_zero ? s_a : 32'd0)
                              : (b_zero ? 32'hFFFF_FFFF : s_a);
`else
    assign fast_hit = 1'b0;
    assign fast_res = 32'd0;
`endif

    // ---------------- restoring step ----------------
    logic [32:0] shifted, diff;
    logic        take;
    logic [31:0] rem_nxt, quo_nxt, quo_fin, rem_fin, fin_res;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = ~diff[32];
    assign rem_nxt = take ? diff[31:0] : shifted[31:0];
    assign quo_nxt = {quo_q[30:0], take};
    assign quo_fin = neg_quo_q ? (32'd0 - quo_nxt) : quo_nxt;
    assign rem_fin = neg_rem_q ? (32'd0 - rem_nxt) : rem_nxt;
    assign fin_res = op_rem_q ? rem_fin : quo_fin;

    logic owner_flush;
    assign owner_flush = owner_q ? c1_flush_i : c0_flush_i;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;   // core 0 wins the first tie
            op_rem_q    <= 1'b0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            cnt_q       <= 5'd0;
            c0_valid_o  <= 1'b0;
            c1_valid_o  <= 1'b0;
            c0_result_o <= 32'd0;
            c1_result_o <= 32'd0;
        end else begin
            c0_valid_o <= 1'b0;
            c1_valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q   <= grant_core;
                        op_rem_q  <= s_op[1];
                        quo_q     <= a_mag;
                        rem_q     <= 32'd0;
                        dvs_q     <= b_mag;
                        // A zero divisor always yields an all-ones quotient, regardless of sign.
                        neg_quo_q <= (a_neg ^ b_neg) & ~b_zero;
                        neg_rem_q <= a_neg;
                        cnt_q     <= 5'd0;
                        if (fast_hit) begin
                            state_q <= DONE;
                            if (grant_core) begin
                                c1_result_o <= fast_res;
                                c1_valid_o  <= 1'b1;
                            end else begin
                                c0_result_o <= fast_res;
                                c0_valid_o  <= 1'b1;
                            end
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (owner_flush) begin
                        state_q <= IDLE;
                        last_q  <= owner_q;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= DONE;
                            if (owner_q) begin
                                c1_result_o <= fin_res;
                                c1_valid_o  <= 1'b1;
                            end else begin
                                c0_result_o <= fin_res;
                                c0_valid_o  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // valid_o is already visible here. A flush in this cycle only
                    // shares the return to IDLE.
                    state_q <= IDLE;
                    last_q  <= owner_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_arbiter.sv
module tb_riscv_div_arbiter;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
    localparam int LAT = 33;
`ifdef RISCV_DIV_FASTPATH_EN
    localparam int LAT_FAST = 1;
`else
    localparam int LAT_FAST = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req, c0_flush, c0_accept, c0_valid;
    logic [1:0]  c0_op;
    logic [31:0] c0_a, c0_b, c0_result;
    logic        c1_req, c1_flush, c1_accept, c1_valid;
    logic [1:0]  c1_op;
    logic [31:0] c1_a, c1_b, c1_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_div_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .c0_req_i(c0_req), .c0_op_i(c0_op), .c0_a_i(c0_a), .c0_b_i(c0_b),
        .c0_flush_i(c0_flush), .c0_accept_o(c0_accept), .c0_valid_o(c0_valid),
        .c0_result_o(c0_result),
        .c1_req_i(c1_req), .c1_op_i(c1_op), .c1_a_i(c1_a), .c1_b_i(c1_b),
        .c1_flush_i(c1_flush), .c1_accept_o(c1_accept), .c1_valid_o(c1_valid),
        .c1_result_o(c1_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic acc(input int core);
        return (core == 1) ? c1_accept : c0_accept;
    endfunction

    function automatic logic vld(input int core);
        return (core == 1) ? c1_valid : c0_valid;
    endfunction

    function automatic logic [31:0] res(input int core);
        return (core == 1) ? c1_result : c0_result;
    endfunction

    task automatic drive(input int core, input logic req, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (core == 1) begin
            c1_req = req; c1_op = op; c1_a = a; c1_b = b;
        end else begin
            c0_req = req; c0_op = op; c0_a = a; c0_b = b;
        end
    endtask

    task automatic set_req(input int core, input logic v);
        if (core == 1) c1_req = v;
        else           c0_req = v;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Entry: one cycle after the accept edge. Counts cycles from the accept cycle
    // until valid_o, and notes any valid pulse seen on the other core.
    task automatic wait_valid(input int core, output int n, output logic other_seen);
        n = 1;
        other_seen = 1'b0;
        while (!vld(core) && n < 100) begin
            if (vld(1 - core)) other_seen = 1'b1;
            step();
            n++;
        end
        if (vld(1 - core)) other_seen = 1'b1;
    endtask

    // Single-core transaction: accept in the current IDLE cycle, then latency,
    // result, isolation from the other core, and single-cycle pulse width.
    task automatic issue(input int core, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat,
                         input string tag);
        int   n;
        logic os;
        drive(core, 1'b1, op, a, b);
        #1;
        chk({tag, " accept"}, 32'(acc(core)), 32'd1);
        step();
        set_req(core, 1'b0);
        wait_valid(core, n, os);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, res(core), exp);
        chk({tag, " other valid"}, 32'(os), 32'd0);
        step();
        chk({tag, " pulse width"}, 32'(vld(core)), 32'd0);
    endtask

    // Both cores request in the same IDLE cycle; 'first' is the core expected to win.
    task automatic both(input int first,
                        input logic [1:0] op_f, input logic [31:0] a_f, input logic [31:0] b_f,
                        input logic [31:0] e_f,
                        input logic [1:0] op_s, input logic [31:0] a_s, input logic [31:0] b_s,
                        input logic [31:0] e_s, input string tag);
        int   n;
        logic os;
        int   second;
        second = 1 - first;
        drive(first, 1'b1, op_f, a_f, b_f);
        drive(second, 1'b1, op_s, a_s, b_s);
        #1;
        chk({tag, " first accept"}, 32'(acc(first)), 32'd1);
        chk({tag, " second held"}, 32'(acc(second)), 32'd0);
        step();
        set_req(first, 1'b0);
        wait_valid(first, n, os);
        chk({tag, " first latency"}, 32'(n), 32'(LAT));
        chk({tag, " first result"}, res(first), e_f);
        step();  // T+34: back in IDLE with the second core still requesting
        chk({tag, " second accept T+34"}, 32'(acc(second)), 32'd1);
        step();
        set_req(second, 1'b0);
        wait_valid(second, n, os);
        chk({tag, " second latency"}, 32'(n), 32'(LAT));
        chk({tag, " second result"}, res(second), e_s);
        chk({tag, " no stray valid"}, 32'(os), 32'd0);
        step();
    endtask

    initial begin
        int   n;
        logic os;
        logic seen;

        rst_n = 1'b0;
        drive(0, 1'b1, OP_DIVU, 32'd1, 32'd1);  // request held high during reset
        drive(1, 1'b0, OP_DIVU, 32'd0, 32'd0);
        c0_flush = 1'b0;
        c1_flush = 1'b0;
        #12;
        chk("reset c0_accept", 32'(c0_accept), 32'd0);
        chk("reset c0_valid", 32'(c0_valid), 32'd0);
        chk("reset c1_valid", 32'(c1_valid), 32'd0);
        chk("reset c0_result", c0_result, 32'd0);
        chk("reset c1_result", c1_result, 32'd0);
        c0_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Single-core unsigned and signed operations
        issue(0, OP_DIVU, 32'd100, 32'd7, 32'd14, LAT, "c0 DIVU 100/7");
        issue(0, OP_REMU, 32'd100, 32'd7, 32'd2, LAT, "c0 REMU 100/7");
        issue(1, OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT, "c1 DIV -100/7");
        issue(1, OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT, "c1 REM -100/7");

        // Round-robin: core 1 was served last, so core 0 wins the tie.
        both(0, OP_DIVU, 32'd1000, 32'd10, 32'd100,
                OP_REMU, 32'd1000, 32'd7, 32'd6, "rr1");
        both(0, OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,
                OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, "rr2");

        // Special cases
        issue(0, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_FAST, "DIV 5/0");
        issue(0, OP_REM, 32'd5, 32'd0, 32'd5, LAT_FAST, "REM 5/0");
        issue(0, OP_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, LAT_FAST, "DIV -100/0");
        issue(0, OP_REM, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, LAT_FAST, "REM -100/0");
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST, "DIV ovf");
        issue(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FAST, "REM ovf");
        issue(0, OP_DIVU, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, LAT_FAST, "DIVU b=1");
        issue(0, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT, "DIVU big/max");

        // Core 0 was served last, so core 1 now wins the tie.
        both(1, OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF,
                OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, "rr3");

        // Flush of the owner in BUSY; core 1 is pending behind it.
        drive(0, 1'b1, OP_DIVU, 32'd12345, 32'd5);
        #1;
        chk("flush c0 accept", 32'(c0_accept), 32'd1);
        step();                                  // T+1
        c0_req = 1'b0;
        drive(1, 1'b1, OP_DIVU, 32'd77, 32'd7);
        repeat (9) @(posedge clk);
        #1;                                      // T+10
        c0_flush = 1'b1;
        #1;
        chk("flush c1 held in BUSY", 32'(c1_accept), 32'd0);
        step();                                  // T+11
        c0_flush = 1'b0;
        chk("flush c1 accept T+11", 32'(c1_accept), 32'd1);
        chk("flush c0 no valid", 32'(c0_valid), 32'd0);
        chk("flush c0 result held", c0_result, 32'hF);
        step();
        c1_req = 1'b0;
        wait_valid(1, n, os);
        chk("flush c1 latency", 32'(n), 32'(LAT));
        chk("flush c1 result", c1_result, 32'd11);
        chk("flush c0 never valid", 32'(os), 32'd0);
        step();

        // Reset in the middle of BUSY
        drive(0, 1'b1, OP_DIVU, 32'd9, 32'd3);
        #1;
        chk("rst c0 accept", 32'(c0_accept), 32'd1);
        step();
        c0_req = 1'b0;
        repeat (19) @(posedge clk);
        #1;                                      // T+20
        rst_n = 1'b0;
        #1;
        chk("midrst c0_valid", 32'(c0_valid), 32'd0);
        chk("midrst c0_result", c0_result, 32'd0);
        chk("midrst c1_result", c1_result, 32'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (c0_valid || c1_valid) seen = 1'b1;
            step();
        end
        chk("post-rst no valid", 32'(seen), 32'd0);
        issue(0, OP_DIVU, 32'd50, 32'd5, 32'd10, LAT, "post-rst DIVU 50/5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
